// File: rtl/switch_arbiter_if.sv
// Request/grant bundle between the requesters and the crossbar arbiter.
// The master side raises requests; the slave side (the arbiter) returns the grant.
interface switch_arbiter_if #(
    parameter int N    = 8,
    parameter int SELW = 3
);
    logic [N-1:0]    REQ;
    logic            DONE;
    logic [SELW-1:0] SEL;
    logic [N-1:0]    GNT;
    logic            VALID;
    logic            FORCED;

    modport master (output REQ, output DONE, input SEL, input GNT, input VALID, input FORCED);
    modport slave  (input REQ, input DONE, output SEL, output GNT, output VALID, output FORCED);
endinterface

// File: rtl/switch_arbiter.sv
// Round-robin arbiter driving the Switcher crossbar select: one grant per transaction,
// bounded by MAX_HOLD, followed by a one-cycle turnaround slot before the next grant.
module switch_arbiter #(
    parameter int N        = 8,
    parameter int SELW     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    switch_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [SELW-1:0] ptr_r;
    logic [CW-1:0]   cnt_r;
    logic [SELW-1:0] sel_r;
    logic [N-1:0]    gnt_r;
    logic            valid_r;
    logic            forced_r;

    logic [SELW:0]   pick_s;
    logic            done_s;
    logic            drop_s;
    logic            limit_s;
    logic            release_s;

    // Returns {found, index} of the first set request scanning upward from ptr with wrap.
    function automatic logic [SELW:0] rr_pick(input logic [N-1:0] req, input logic [SELW-1:0] ptr);
        logic [SELW:0]   res;
        logic [SELW-1:0] idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = SELW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection and release-condition decode.
    always_comb begin
        pick_s    = rr_pick(bus.REQ, ptr_r);
        done_s    = bus.DONE;
        drop_s    = ~bus.REQ[sel_r];
        limit_s   = (cnt_r == CW'(MAX_HOLD - 1));
        release_s = done_s | drop_s | limit_s;
    end

    // Arbiter state machine with all outputs held in registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            cnt_r    <= '0;
            sel_r    <= '0;
            gnt_r    <= '0;
            valid_r  <= 1'b0;
            forced_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    forced_r <= 1'b0;
                    if (pick_s[SELW]) begin
                        state_r <= GRANT;
                        sel_r   <= pick_s[SELW-1:0];
                        gnt_r   <= {{(N-1){1'b0}}, 1'b1} << pick_s[SELW-1:0];
                        valid_r <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (release_s) begin
                        state_r  <= TURN;
                        valid_r  <= 1'b0;
                        gnt_r    <= '0;
                        ptr_r    <= (sel_r == SELW'(N - 1)) ? SELW'(0) : sel_r + SELW'(1);
                        // Only a pure timeout counts as forced; a coincident DONE or withdrawal does not.
                        forced_r <= limit_s & ~done_s & ~drop_s;
                    end else begin
                        state_r <= GRANT;
                    end
                end
                TURN: begin
                    forced_r <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    valid_r  <= 1'b0;
                    gnt_r    <= '0;
                    forced_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SEL    = sel_r;
    assign bus.GNT    = gnt_r;
    assign bus.VALID  = valid_r;
    assign bus.FORCED = forced_r;
endmodule
